// File: rtl/key_event_scheduler.sv
// key_event_scheduler
//   Turns debounced active-low key levels into one press event per press,
//   arbitrates the keys round-robin onto a single event channel, queues the
//   events in a small FIFO and hands them to a consumer over valid/ready.
//   A sticky ovf flag records that at least one event was merged away.
//
//   Optional macro KEY_AUTO_REPEAT_EN: per-key hold counters generate
//   auto-repeat events (evt_repeat = 1) while a key stays held. Without the
//   macro no counters exist and evt_repeat is constant 0.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   key_db_n   debounced key levels, 0 = pressed (synchronous to clk)
//   evt_valid  FIFO head holds an event
//   evt_ready  consumer takes the head event this cycle
//   evt_code   key index of the head event
//   evt_repeat head event is an auto-repeat
//   fifo_level number of stored events
//   ovf        sticky lost-event flag
//   ovf_clr    clears ovf (a simultaneous new overflow wins)
module key_event_scheduler #(
   parameter int NUM_KEYS      = 3,
   parameter int CODE_W        = 2,
   parameter int FIFO_DEPTH    = 4,
   parameter int HOLD_CYCLES   = 25000000,
   parameter int REPEAT_CYCLES = 5000000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_KEYS-1:0]           key_db_n,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [CODE_W-1:0]             evt_code,
   output logic                          evt_repeat,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          ovf,
   input  logic                          ovf_clr
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(NUM_KEYS);

   generate
      if (NUM_KEYS < 2 || NUM_KEYS > 8 || (1 << CODE_W) < NUM_KEYS ||
          FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
          REPEAT_CYCLES < 1 || HOLD_CYCLES < REPEAT_CYCLES) begin : g_bad_param
         $error("key_event_scheduler: illegal parameter combination");
      end
   endgenerate

   logic [NUM_KEYS-1:0] key_r;
   logic [NUM_KEYS-1:0] lock;      // key was held through reset; ignore until released
   logic [NUM_KEYS-1:0] press;
   logic [NUM_KEYS-1:0] rpt_fire;
   logic [NUM_KEYS-1:0] evt_in;
   logic [NUM_KEYS-1:0] pending;
   logic [NUM_KEYS-1:0] gnt_vec;
   logic [LW-1:0]       last_grant;
   logic [LW-1:0]       gnt_idx;
   logic                gnt_vld;
   logic                pop;
   logic                can_push;
   logic                ovf_set;

   logic [CODE_W-1:0]   mem_code [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [AW:0]         count;

   // key_r restarts released, so a key still held when reset lifts would look
   // like a fresh press; lock masks it until the key is seen released.
   assign press  = key_r & ~key_db_n & ~lock;
   assign evt_in = press | rpt_fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         key_r <= '1;
         lock  <= ~key_db_n;
      end else begin
         key_r <= key_db_n;
         lock  <= lock & ~key_db_n;
      end
   end

   // FIFO status; depth is a power of two so the MSB of count means full
   assign evt_valid  = (count != '0);
   assign fifo_level = count;
   assign evt_code   = mem_code[rd_ptr];
   assign pop        = evt_valid & evt_ready;
   assign can_push   = ~count[AW] | pop;

   // Round-robin: first pending key searching upward from last_grant+1
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = last_grant;
      for (int k = 1; k <= NUM_KEYS; k++) begin
         int idx;
         idx = int'(last_grant) + k;
         if (idx >= NUM_KEYS) idx = idx - NUM_KEYS;
         if (!gnt_vld && can_push && pending[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = LW'(idx);
         end
      end
   end

   always_comb begin
      gnt_vec = '0;
      if (gnt_vld) gnt_vec[gnt_idx] = 1'b1;
   end

   // A new event on a key that stays pending is merged, i.e. lost
   assign ovf_set = |(evt_in & pending & ~gnt_vec);

   always_ff @(posedge clk) begin
      if (rst) begin
         pending    <= '0;
         last_grant <= LW'(NUM_KEYS - 1);
         ovf        <= 1'b0;
      end else begin
         pending <= (pending & ~gnt_vec) | evt_in;
         if (gnt_vld) last_grant <= gnt_idx;
         if (ovf_set)      ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

   // Push at full is legal only alongside a pop; the write then lands in
   // the slot being vacated, since wr_ptr == rd_ptr.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_code[i] <= '0;
      end else begin
         if (gnt_vld) begin
            mem_code[wr_ptr] <= CODE_W'(gnt_idx);
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (gnt_vld && !pop)      count <= count + (AW+1)'(1);
         else if (!gnt_vld && pop) count <= count - (AW+1)'(1);
      end
   end

`ifdef KEY_AUTO_REPEAT_EN
   localparam int MAXC   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W  = $clog2(MAXC + 1);
   localparam logic [CNT_W-1:0] FIRE_AT = CNT_W'(HOLD_CYCLES - 1);
   // Reloading to HOLD-REPEAT makes the next fire REPEAT cycles later
   localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES);

   logic [NUM_KEYS-1:0] pend_rep;
   logic                mem_rep [FIFO_DEPTH];

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      logic [CNT_W-1:0] hold_cnt;
      logic             run;

      assign run         = ~key_db_n[g] & ~press[g] & ~lock[g];
      assign rpt_fire[g] = run & (hold_cnt == FIRE_AT);

      always_ff @(posedge clk) begin
         if (rst || !run)  hold_cnt <= '0;
         else if (rpt_fire[g]) hold_cnt <= RELOAD;
         else              hold_cnt <= hold_cnt + CNT_W'(1);
      end
   end

   // Flag follows the most recent event merged into the pending bit
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_rep <= '0;
      end else begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (evt_in[i])       pend_rep[i] <= rpt_fire[i];
            else if (gnt_vec[i]) pend_rep[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_rep[i] <= 1'b0;
      end else if (gnt_vld) begin
         mem_rep[wr_ptr] <= pend_rep[gnt_idx];
      end
   end

   assign evt_repeat = mem_rep[rd_ptr];
`else
   assign rpt_fire   = '0;
   assign evt_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_scheduler.sv
// Self-checking bench for key_event_scheduler: a queue-based event model is
// compared with the DUT every cycle, and directed scenarios pin the model
// with hand-computed values.
module tb_key_event_scheduler;
   localparam int NK = 3;
   localparam int CW = 2;
   localparam int FD = 4;
   localparam int HC = 20;
   localparam int RC = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NK-1:0] key_db_n = '1;
   logic          evt_ready = 1'b0;
   logic          ovf_clr = 1'b0;
   logic          evt_valid;
   logic [CW-1:0] evt_code;
   logic          evt_repeat;
   logic [$clog2(FD):0] fifo_level;
   logic          ovf;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   key_event_scheduler #(
      .NUM_KEYS(NK), .CODE_W(CW), .FIFO_DEPTH(FD),
      .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)
   ) dut (
      .clk(clk), .rst(rst), .key_db_n(key_db_n),
      .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_code(evt_code), .evt_repeat(evt_repeat),
      .fifo_level(fifo_level), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Queue entries: code + 256*repeat. Age counts edges since the press edge.
   int          mq[$];
   bit [NK-1:0] mpend, mprep, mprev, mlock;
   int          mlg;
   bit          movf;
   int          mage[NK];

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         mpend = '0; mprep = '0; mprev = '1; mlock = ~key_db_n;
         mlg = NK - 1; movf = 1'b0;
         for (int i = 0; i < NK; i++) mage[i] = -1;
      end else begin
         bit pop, blk, nov;
         int g;
         bit [NK-1:0] pr, rp;
         pop = (mq.size() > 0) && evt_ready;
         blk = (mq.size() == FD) && !pop;
         g = -1;
         if (!blk)
            for (int k = 1; k <= NK; k++)
               if (g < 0 && mpend[(mlg + k) % NK]) g = (mlg + k) % NK;
         for (int i = 0; i < NK; i++) begin
            pr[i] = mprev[i] && !key_db_n[i] && !mlock[i];
            rp[i] = 1'b0;
            if (!key_db_n[i] && !mlock[i]) begin
               if (pr[i]) mage[i] = 0;
               else if (mage[i] >= 0) begin
                  mage[i]++;
`ifdef KEY_AUTO_REPEAT_EN
                  rp[i] = (mage[i] >= HC) && ((mage[i] - HC) % RC == 0);
`endif
               end
            end else begin
               mage[i] = -1;
            end
         end
         nov = 1'b0;
         for (int i = 0; i < NK; i++)
            if ((pr[i] || rp[i]) && mpend[i] && g != i) nov = 1'b1;
         if (pop) void'(mq.pop_front());
         if (g >= 0) begin
            mq.push_back(g + (mprep[g] ? 256 : 0));
            mpend[g] = 1'b0; mprep[g] = 1'b0; mlg = g;
         end
         for (int i = 0; i < NK; i++)
            if (pr[i] || rp[i]) begin mpend[i] = 1'b1; mprep[i] = rp[i]; end
         if (nov) movf = 1'b1;
         else if (ovf_clr) movf = 1'b0;
         for (int i = 0; i < NK; i++) if (key_db_n[i]) mlock[i] = 1'b0;
         mprev = key_db_n;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (!rst) begin
         chk("m_valid", evt_valid, mq.size() != 0);
         chk("m_level", fifo_level, mq.size());
         chk("m_ovf", ovf, movf);
         if (mq.size() != 0) begin
            chk("m_code", evt_code, mq[0] % 256);
            chk("m_repeat", evt_repeat, mq[0] / 256);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   int exp2[5] = '{0, 1, 2, 0, 2};
   int exp4[4] = '{1, 1, 1, 0};
   int cnt2, nrep, npress, first_rep, late;

   initial begin
      evt_ready = 1'b1;
      tick(2);
      chk("rst_valid", evt_valid, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_code", evt_code, 0);
      chk("rst_repeat", evt_repeat, 0);
      rst = 1'b0;
      tick(1);

      // single press of key 1: valid two edges after the change
      key_db_n = 3'b101;
      tick(1); chk("t1_lat", evt_valid, 0);
      tick(1); chk("t1_valid", evt_valid, 1);
      chk("t1_code", evt_code, 1);
      chk("t1_rep", evt_repeat, 0);
      tick(1); chk("t1_once", evt_valid, 0);
      key_db_n = '1;
      tick(2); chk("t1_once2", evt_valid, 0);

      // simultaneous presses, round-robin order
      evt_ready = 1'b0;
      do_reset();
      key_db_n = 3'b000; tick(4);
      chk("t2_level3", fifo_level, 3);
      key_db_n = '1; tick(1);
      key_db_n = 3'b010; tick(2);
      chk("t2_level4", fifo_level, 4);
      key_db_n = '1;
      evt_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("t2_order%0d", j), evt_code, exp2[j]);
         tick(1);
      end
      chk("t2_empty", fifo_level, 0);
      chk("t2_ovf", ovf, 0);

      // full FIFO, key 2 pressed twice -> held pending, overflow
      evt_ready = 1'b0;
      do_reset();
      for (int j = 0; j < 4; j++) begin
         key_db_n = 3'b110; tick(1);
         key_db_n = '1;     tick(1);
      end
      tick(1);
      chk("t3_full", fifo_level, 4);
      key_db_n = 3'b011; tick(1);
      key_db_n = '1;     tick(1);
      chk("t3_no_ovf_yet", ovf, 0);
      key_db_n = 3'b011; ovf_clr = 1'b1; tick(1);
      ovf_clr = 1'b0;
      chk("t3_set_wins", ovf, 1);
      chk("t3_held", fifo_level, 4);
      key_db_n = '1; ovf_clr = 1'b1; tick(1);
      ovf_clr = 1'b0;
      chk("t3_clr", ovf, 0);
      evt_ready = 1'b1;
      cnt2 = 0;
      repeat (8) begin
         if (evt_valid && evt_code == 2) cnt2++;
         tick(1);
      end
      chk("t3_key2_once", cnt2, 1);

      // pop and push at full in the same cycle
      evt_ready = 1'b0;
      do_reset();
      for (int j = 0; j < 4; j++) begin
         key_db_n = 3'b101; tick(1);
         key_db_n = '1;     tick(1);
      end
      tick(1);
      key_db_n = 3'b110; tick(1);
      key_db_n = '1; evt_ready = 1'b1; tick(1);
      evt_ready = 1'b0;
      chk("t4_level", fifo_level, 4);
      evt_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("t4_order%0d", j), evt_code, exp4[j]);
         tick(1);
      end

      // reset mid-operation with key 1 held
      evt_ready = 1'b0;
      do_reset();
      key_db_n = 3'b110; tick(1);
      key_db_n = '1;     tick(1);
      key_db_n = 3'b011; tick(1);
      key_db_n = '1;     tick(1);
      key_db_n = 3'b101; tick(3);
      chk("t5_queued", fifo_level, 3);
      rst = 1'b1; tick(1);
      chk("t5_rst_valid", evt_valid, 0);
      chk("t5_rst_level", fifo_level, 0);
      chk("t5_rst_ovf", ovf, 0);
      chk("t5_rst_code", evt_code, 0);
      tick(1);
      rst = 1'b0; evt_ready = 1'b1;
      tick(5);
      chk("t5_no_evt", evt_valid, 0);
      key_db_n = '1;     tick(1);
      key_db_n = 3'b101; tick(2);
      chk("t5_repress", evt_valid, 1);
      chk("t5_code", evt_code, 1);
      key_db_n = '1; tick(2);

`ifdef KEY_AUTO_REPEAT_EN
      // hold key 0 for 50 cycles: press at 2, repeats at 22, 30, 38, 46
      evt_ready = 1'b1;
      do_reset();
      key_db_n = 3'b110;
      nrep = 0; npress = 0; first_rep = -1; late = 0;
      for (int i = 1; i <= 50; i++) begin
         tick(1);
         if (evt_valid) begin
            if (evt_repeat) begin
               nrep++;
               if (first_rep < 0) first_rep = i;
            end else npress++;
         end
      end
      key_db_n = '1;
      repeat (20) begin
         tick(1);
         if (evt_valid) late++;
      end
      chk("t6_press", npress, 1);
      chk("t6_repeats", nrep, 4);
      chk("t6_first_rep", first_rep, 22);
      chk("t6_stop", late, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
